tour_distance_acc: RTL and testbench

//  Parametrised tour-length accumulator for the GA fitness path: sums table distances between adjacent

---
 rtl/tour_distance_acc.sv | 130 +++++++++++++
 tb/tb_tour_distance_acc.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/tour_distance_acc.sv
// tour_distance_acc: sums distance-table entries over adjacent city pairs of one packed tour.
// Latency: start sampled at edge 0 -> done pulse in cycle E + TABLE_LATENCY + 1.
// Backpressure: none; start is only honoured in IDLE, later pulses are dropped (no queueing).
//
// Ports: clk, rst_n (async active-low), start, tour (packed cities, city i at i*CITY_W),
//        table_addr/table_dout (external distance table, read latency TABLE_LATENCY),
//        busy, done (1-cycle pulse), distance (held until next start), overflow (sticky saturation).
// Optional feature macro: CLOSED_TOUR_EN adds the return edge (last city -> first city).
module tour_distance_acc #(
  parameter int NUM_CITIES    = 16,
  parameter int CITY_W        = 5,
  parameter int DIST_W        = 9,
  parameter int SUM_W         = 13,
  parameter int TABLE_LATENCY = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [NUM_CITIES*CITY_W-1:0]   tour,
  output logic [2*CITY_W-1:0]            table_addr,
  input  logic [DIST_W-1:0]              table_dout,
  output logic                           busy,
  output logic                           done,
  output logic [SUM_W-1:0]               distance,
  output logic                           overflow
);

`ifdef CLOSED_TOUR_EN
  localparam int E = NUM_CITIES;
`else
  localparam int E = NUM_CITIES - 1;
`endif
  localparam int KW = $clog2(NUM_CITIES);
  localparam int DW = (TABLE_LATENCY > 1) ? $clog2(TABLE_LATENCY) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                          state, state_nxt;
  logic [NUM_CITIES*CITY_W-1:0]    tour_q;
  logic [KW-1:0]                   k;
  logic [KW-1:0]                   k_nxt;
  logic [DW-1:0]                   dcnt;
  logic [TABLE_LATENCY-1:0]        vld_sr;
  logic [2*CITY_W-1:0]             addr_q;
  logic [2*CITY_W-1:0]             cur_addr;
  logic [CITY_W-1:0]               city [NUM_CITIES];
  logic [CITY_W-1:0]               city_a, city_b;
  logic [SUM_W:0]                  sum;
  logic                            issue;
  logic                            accept;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_ISSUE;
      S_ISSUE: if (k == KW'(E - 1)) state_nxt = S_DRAIN;
      S_DRAIN: if (dcnt == DW'(TABLE_LATENCY - 1)) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy   = (state != S_IDLE);
    done   = (state == S_DONE);
    issue  = (state == S_ISSUE);
    accept = (state == S_IDLE) && start;
  end

  // Unpack the captured tour into a city array for indexed access
  always_comb begin
    for (int i = 0; i < NUM_CITIES; i++) city[i] = tour_q[i*CITY_W +: CITY_W];
  end

  // Successor wraps to city 0 only for the closing edge of a closed tour
  assign k_nxt    = (k == KW'(NUM_CITIES - 1)) ? '0 : k + 1'b1;
  assign city_a   = city[k];
  assign city_b   = city[k_nxt];
  assign cur_addr = (city_a < city_b) ? {city_a, city_b} : {city_b, city_a};

  // Drive live address while issuing, otherwise hold the last issued one
  assign table_addr = issue ? cur_addr : addr_q;

  assign sum = {1'b0, distance} + (SUM_W+1)'(table_dout);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tour_q   <= '0;
      k        <= '0;
      dcnt     <= '0;
      vld_sr   <= '0;
      addr_q   <= '0;
      distance <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) begin
        tour_q   <= tour;
        k        <= '0;
        dcnt     <= '0;
        distance <= '0;
        overflow <= 1'b0;
      end
      if (issue) begin
        k      <= k + 1'b1;
        addr_q <= cur_addr;
      end
      if (state == S_DRAIN) dcnt <= dcnt + 1'b1;
      // Each issued cycle carries a tag that emerges when its read data is valid
      vld_sr <= (vld_sr << 1) | TABLE_LATENCY'(issue);
      if (vld_sr[TABLE_LATENCY-1]) begin
        // Once saturated, stay saturated for the rest of the run
        if (sum[SUM_W] || overflow) begin
          distance <= '1;
          overflow <= 1'b1;
        end else begin
          distance <= sum[SUM_W-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_tour_distance_acc.sv
module tb_tour_distance_acc;

`ifdef CLOSED_TOUR_EN
  localparam int E = 16;
`else
  localparam int E = 15;
`endif
  localparam int EXP_ASC = (E == 16) ? 240 : 225;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [79:0] tour;
  int          mode;

  logic [9:0]  a_addr, b_addr;
  logic [8:0]  a_dout, b_dout;
  logic        a_busy, a_done, a_ovf, b_busy, b_done, b_ovf;
  logic [12:0] a_dist;
  logic [11:0] b_dist;

  logic [9:0]  pa;
  logic [9:0]  pb [3];

  int n_chk = 0;
  int n_pass = 0;

  int da, db, na, nb, bad;
  logic [9:0] fa;

  always #5 clk = ~clk;

  tour_distance_acc dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .tour(tour),
    .table_addr(a_addr), .table_dout(a_dout),
    .busy(a_busy), .done(a_done), .distance(a_dist), .overflow(a_ovf)
  );

  tour_distance_acc #(.SUM_W(12), .TABLE_LATENCY(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .tour(tour),
    .table_addr(b_addr), .table_dout(b_dout),
    .busy(b_busy), .done(b_done), .distance(b_dist), .overflow(b_ovf)
  );

  function automatic logic [8:0] dist_of(input logic [9:0] ad, input int m);
    if (m == 1) return 9'd511;
    if (m == 2) return 9'd0;
    return 9'(ad[9:5]) + 9'(ad[4:0]);
  endfunction

  // Distance table models with latency 1 (dut_a) and 3 (dut_b)
  always @(posedge clk) begin
    pa    <= a_addr;
    pb[0] <= b_addr;
    pb[1] <= pb[0];
    pb[2] <= pb[1];
  end
  assign a_dout = dist_of(pa, mode);
  assign b_dout = dist_of(pb[2], mode);

  function automatic logic [79:0] mk_tour(input int kind);
    logic [79:0] t;
    t = '0;
    for (int i = 0; i < 16; i++) begin
      if (kind == 0)      t[i*5 +: 5] = 5'(i);
      else if (kind == 1) t[i*5 +: 5] = 5'(15 - i);
      else                t[i*5 +: 5] = 5'd15;
    end
    return t;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // One run: pulse start in cycle 0, observe cycles 1..40 on the falling edge
  task automatic run_tour(input logic [79:0] t, input bit p5, input bit chg3, input bit rst8);
    da = 0; db = 0; na = 0; nb = 0; bad = 0; fa = '0;
    @(negedge clk);
    tour  = t;
    start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 1) fa = a_addr;
      if (a_addr[9:5] > a_addr[4:0]) bad = bad + 1;
      if (a_done) begin na = na + 1; if (da == 0) da = c; end
      if (b_done) begin nb = nb + 1; if (db == 0) db = c; end
      if (p5 && (c == 5 || c == 17)) start = 1'b1;
      if (chg3 && c == 3) tour = mk_tour(2);
      if (rst8 && c == 8) begin
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(a_busy), 32'd0);
        chk("rst_mid_done", 32'(a_done), 32'd0);
        chk("rst_mid_dist", 32'(a_dist), 32'd0);
        chk("rst_mid_ovf",  32'(a_ovf),  32'd0);
      end
      if (rst8 && c == 9) rst_n = 1'b1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    mode  = 0;
    tour  = mk_tour(0);
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(a_busy), 32'd0);
    chk("reset_done", 32'(a_done), 32'd0);
    chk("reset_dist", 32'(a_dist), 32'd0);
    chk("reset_ovf",  32'(a_ovf),  32'd0);
    chk("reset_addr", 32'(a_addr), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Ascending tour
    run_tour(mk_tour(0), 1'b0, 1'b0, 1'b0);
    chk("asc_done_cyc_a", 32'(da), 32'(E + 2));
    chk("asc_done_cyc_b", 32'(db), 32'(E + 4));
    chk("asc_dist_a", 32'(a_dist), 32'(EXP_ASC));
    chk("asc_ovf_a",  32'(a_ovf),  32'd0);
    chk("asc_dist_b", 32'(b_dist), 32'(EXP_ASC));
    chk("asc_ndone_a", 32'(na), 32'd1);

    // Descending tour: addresses must be min-first
    run_tour(mk_tour(1), 1'b0, 1'b0, 1'b0);
    chk("desc_first_addr", 32'(fa), 32'd463);
    chk("desc_minfirst", 32'(bad), 32'd0);
    chk("desc_dist_a", 32'(a_dist), 32'(EXP_ASC));

    // Constant 511: fits 13 bits, saturates 12 bits
    mode = 1;
    run_tour(mk_tour(0), 1'b0, 1'b0, 1'b0);
    chk("sat_dist_a", 32'(a_dist), 32'(E * 511));
    chk("sat_ovf_a",  32'(a_ovf),  32'd0);
    chk("sat_dist_b", 32'(b_dist), 32'd4095);
    chk("sat_ovf_b",  32'(b_ovf),  32'd1);
    mode = 2;
    run_tour(mk_tour(0), 1'b0, 1'b0, 1'b0);
    chk("zero_dist_b", 32'(b_dist), 32'd0);
    chk("zero_ovf_b",  32'(b_ovf),  32'd0);
    chk("zero_dist_a", 32'(a_dist), 32'd0);
    mode = 0;

    // Re-pulsed start and tour change after capture
    run_tour(mk_tour(0), 1'b1, 1'b1, 1'b0);
    chk("ign_dist_a", 32'(a_dist), 32'(EXP_ASC));
    chk("ign_ndone_a", 32'(na), 32'd1);
    chk("ign_ndone_b", 32'(nb), 32'd1);
    chk("ign_done_cyc_a", 32'(da), 32'(E + 2));
    chk("ign_busy_b_end", 32'(b_busy), 32'd0);

    // Reset mid-run aborts, then a clean run
    run_tour(mk_tour(0), 1'b0, 1'b0, 1'b1);
    chk("rst_ndone_a", 32'(na), 32'd0);
    chk("rst_ndone_b", 32'(nb), 32'd0);
    run_tour(mk_tour(1), 1'b0, 1'b0, 1'b0);
    chk("post_rst_dist_a", 32'(a_dist), 32'(EXP_ASC));
    chk("post_rst_done_cyc", 32'(da), 32'(E + 2));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
